// File: rtl/mem_reverse_ctrl.sv
// Reversal sequencer for the memory swapper: walks [lo,hi] inward issuing
// one swap per SWAP_LAT+1 cycles and locks out host writes while it owns
// the register file.
module mem_reverse_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned SWAP_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic         host_we,
  output logic         host_we_o,
  output logic         swap_o,
  output logic [N-1:0] addr_a,
  output logic [N-1:0] addr_b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] swap_cnt
);

  localparam int unsigned CW = (SWAP_LAT > 1) ? $clog2(SWAP_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   addr_a_q, addr_a_d;
  logic [N-1:0]   addr_b_q, addr_b_d;
  logic [N-1:0]   swap_cnt_q, swap_cnt_d;
  logic           swap_o_q, swap_o_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  // Next-state logic; outputs are derived from the next state so they line up with it once registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    swap_cnt_d = swap_cnt_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((lo == '0) || (lo > hi)) begin
            err_d = 1'b1;
          end else if (lo == hi) begin
            state_d    = DONE;
            swap_cnt_d = '0;
          end else begin
            state_d    = ISSUE;
            addr_a_d   = lo;
            addr_b_d   = hi;
            // Cleared, then counted for the swap issued on entry to ISSUE.
            swap_cnt_d = N'(1);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(SWAP_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // a < b always holds here, so a+1 and b-1 cannot wrap.
          if ((addr_a_q + N'(1)) < (addr_b_q - N'(1))) begin
            state_d    = ISSUE;
            addr_a_d   = addr_a_q + N'(1);
            addr_b_d   = addr_b_q - N'(1);
            swap_cnt_d = swap_cnt_q + N'(1);
          end else begin
            // Addresses keep the last swapped pair.
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    swap_o_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      swap_cnt_q <= '0;
      swap_o_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      swap_cnt_q <= swap_cnt_d;
      swap_o_q   <= swap_o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Host writes are dropped while the sequencer owns the register file.
  assign host_we_o = host_we & ~busy_q;

  assign swap_o   = swap_o_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_mem_reverse_ctrl.sv
// Scoreboard bench for mem_reverse_ctrl: stimulus pushes expected swap/done/err
// events, a negedge monitor pops and compares them and plays the swapper.
module tb_mem_reverse_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned L = 4;
  localparam int          DEPTH = 256;

  logic         clk = 1'b0;
  logic         reset, start, host_we;
  logic [N-1:0] lo, hi;
  logic         host_we_o, swap_o, busy, done, err;
  logic [N-1:0] addr_a, addr_b, swap_cnt;

  mem_reverse_ctrl #(.N(N), .SWAP_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi),
    .host_we(host_we), .host_we_o(host_we_o), .swap_o(swap_o),
    .addr_a(addr_a), .addr_b(addr_b), .busy(busy), .done(done),
    .err(err), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = swap, 1 = done, 2 = err
  typedef struct {
    int kind;
    int a;
    int b;
    int cnt;
    int at;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_cnt = 0;
  logic [7:0] mem     [DEPTH];
  logic [7:0] exp_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  endtask

  // Monitor: pops one expectation per observed event and acts as the swapper.
  always @(negedge clk) begin
    if (!reset && (swap_o || done || err)) begin
      int kind;
      kind = swap_o ? 0 : (done ? 1 : 2);
      chk("one_event_per_cycle", 32'(int'(swap_o) + int'(done) + int'(err)), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("event_cycle", 32'(cyc), 32'(e.at));
        if (kind == 0) begin
          logic [7:0] t;
          chk("swap_addr_a", 32'(addr_a), 32'(e.a));
          chk("swap_addr_b", 32'(addr_b), 32'(e.b));
          t = mem[addr_a];
          mem[addr_a] = mem[addr_b];
          mem[addr_b] = t;
        end else if (kind == 1) begin
          int bad;
          bad = 0;
          chk("done_swap_cnt", 32'(swap_cnt), 32'(e.cnt));
          chk("done_busy", 32'(busy), 32'd1);
          for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
          chk("mem_contents_bad_words", 32'(bad), 32'd0);
        end else begin
          chk("err_busy", 32'(busy), 32'd0);
          chk("err_swap_cnt", 32'(swap_cnt), 32'(e.cnt));
        end
      end
    end
  end

  task automatic push(input int kind, input int a, input int b, input int cnt, input int at);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.cnt = cnt; e.at = at;
    exp_q.push_back(e);
  endtask

  // Reference: K = floor(len/2) swaps walking inward, one every L+1 cycles.
  task automatic expect_run(input int l, input int h, input int t0);
    if (l == 0 || l > h) begin
      push(2, 0, 0, model_cnt, t0 + 1);
    end else begin
      int k_tot;
      k_tot = (h - l + 1) / 2;
      for (int k = 0; k < k_tot; k++) push(0, l + k, h - k, 0, t0 + 1 + k * (L + 1));
      push(1, 0, 0, k_tot, t0 + 1 + k_tot * (L + 1));
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
      for (int i = l; i <= h; i++) exp_mem[i] = mem[l + h - i];
      model_cnt = k_tot;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input int l, input int h);
    @(posedge clk); #1;
    lo = N'(l); hi = N'(h); start = 1'b1;
    expect_run(l, h, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    drain("drain_events");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; host_we = 1'b0; lo = '0; hi = '0;
    mem_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_swap_o", 32'(swap_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd0);
    chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    reset = 1'b0;

    // Directed cases
    run(2, 5);
    run(10, 14);
    run(0, 4);
    run(7, 3);
    run(9, 9);
    run(250, 255);
    run(1, 2);

    // Host writes gated while busy; a start while busy is ignored
    host_we = 1'b1;
    fork
      run(20, 27);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("host_we_o_busy", 32'(host_we_o), 32'd0);
        lo = N'(3); hi = N'(9); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    #2;
    chk("host_we_o_after_done", 32'(host_we_o), 32'd1);
    host_we = 1'b0;

    // Reset in cycle 3 of a long reversal
    begin
      int t0;
      @(posedge clk); #1;
      lo = N'(1); hi = N'(200); start = 1'b1;
      t0 = cyc;
      push(0, 1, 200, 0, t0 + 1);
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      chk("midrst_cycle", 32'(cyc), 32'(t0 + 4));
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_swap_o", 32'(swap_o), 32'd0);
      chk("midrst_addr_a", 32'(addr_a), 32'd0);
      chk("midrst_addr_b", 32'(addr_b), 32'd0);
      chk("midrst_swap_cnt", 32'(swap_cnt), 32'd0);
      chk("midrst_pending", 32'(exp_q.size()), 32'd0);
      mem_init();
      model_cnt = 0;
      repeat (12) @(posedge clk);
      run(1, 2);
    end

    // Randomized ranges, mostly legal
    for (int it = 0; it < 14; it++) begin
      int l, h, sel;
      sel = int'($urandom_range(0, 5));
      l = int'($urandom_range(1, 255));
      h = l + int'($urandom_range(0, 30));
      if (h > 255) h = 255;
      if (sel == 0) l = 0;
      else if (sel == 1 && l > 1) h = int'($urandom_range(1, 32'(l - 1)));
      run(l, h);
    end

    repeat (10) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_reverse_ctrl.md
# mem_reverse_ctrl

Sequencer that reverses a contiguous address range [lo, hi] of the swapper's register file by issuing a series of swap commands: (lo,hi), (lo+1,hi-1), and so on. It drives the swap, address_A and address_B inputs of the memory swapper. It also gates host writes while a reversal is in flight, so the register file has exactly one owner at a time. Address 0 is the swapper's scratch word and is never a legal range member.

## Interface

Parameters:
- N, 8, address width; must match the swapper's N.
- SWAP_LAT, 4, idle cycles after each swap pulse; must be ≥ the swapper FSM's swap duration (3).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a reversal; sampled only in IDLE.
- lo  in  N  first address of range; sampled with start.
- hi  in  N  last address of range; sampled with start.
- host_we  in  1  host write enable, destined for the swapper's we.
- host_we_o  out  1  gated write enable, connected to the swapper's we.
- swap_o  out  1  one-cycle swap pulse, connected to the swapper's swap input.
- addr_a  out  N  connected to the swapper's address_A.
- addr_b  out  N  connected to the swapper's address_B.
- busy  out  1  high while a reversal is in progress.
- done  out  1  one-cycle pulse when a reversal completes.
- err  out  1  one-cycle pulse when a start is rejected.
- swap_cnt  out  N  number of swaps issued by the current or last reversal.

## Operation

- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered except host_we_o.
- host_we_o = host_we & ~busy (combinational). Host writes are dropped, not queued, while busy.
- IDLE, start=1, lo==0 or lo>hi:
  - err=1 for the next cycle.
  - Stay in IDLE; swap_cnt unchanged.
- IDLE, start=1, lo==hi (and lo≠0):
  - No swap needed; go to DONE.
  - swap_cnt cleared to 0.
- IDLE, start=1, 0<lo<hi:
  - Load a=lo, b=hi; clear swap_cnt.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - swap_o=1, addr_a=a, addr_b=b.
  - swap_cnt increments.
  - Load wait counter with SWAP_LAT-1; go to WAIT.
- WAIT:
  - swap_o=0; addr_a and addr_b held at a and b (the swapper reads them every cycle of its sequence).
  - Counter decrements each cycle.
  - At counter==0: a←a+1, b←b-1. Go to ISSUE if a+1<b-1, else go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in ISSUE, WAIT and DONE; busy=0 in IDLE.
- addr_a and addr_b keep their last values in IDLE.
- start outside IDLE is ignored (no queueing, no err).
- Arithmetic: a and b stay inside [lo,hi] and 1 ≤ a < b whenever a swap is issued, so there is no wrap-around. hi = 2^N-1 is legal. Comparisons are unsigned.
- Swap count K = floor((hi-lo+1)/2). For an odd-length range the middle word is untouched.
- Reset values: state=IDLE; swap_o, busy, done, err = 0; addr_a, addr_b, swap_cnt = 0.
- Reset mid-operation: return to IDLE next cycle and issue no further swaps. The swapper must be reset in the same cycle, because a partially executed swap leaves its data undefined. Reset asserted during the start cycle wins over start.

## Timing

- start sampled at the edge ending cycle 0 → first swap_o in cycle 1; busy rises in cycle 1.
- Swap k (k=0..K-1) pulses in cycle 1+k·(SWAP_LAT+1).
- done is high in cycle 1+K·(SWAP_LAT+1); busy falls in the next cycle.
- lo==hi: done in cycle 1, no swap_o.
- err: high in cycle 1 only; busy stays low.
- A new start is accepted in the first cycle busy is low (back-to-back reversals are allowed).

## Test plan

- Defaults, memory preloaded with mem[i]=i, start with lo=2, hi=5:
  - swap_o in cycles 1 and 6, with (addr_a,addr_b) = (2,5) then (3,4).
  - done in cycle 11; swap_cnt=2; mem[2..5] = 5,4,3,2.
- Odd range, lo=10, hi=14:
  - swaps (10,14) then (11,13); done in cycle 11; mem[12] unchanged.
- Illegal start with lo=0, hi=4, then lo=7, hi=3:
  - err pulse one cycle after each start; busy, swap_o and done stay 0; memory unchanged.
- lo=hi=9:
  - done in cycle 1; swap_cnt=0; no swap_o.
- host_we=1 held during a reversal:
  - host_we_o=0 while busy; host_we_o=1 in the cycle after done.
  - A second start asserted while busy is ignored.
- reset asserted in cycle 3 of a lo=1, hi=200 reversal:
  - busy=0, swap_o=0 and all outputs at reset values from cycle 4.
  - A subsequent start with lo=1, hi=2 completes normally with done in cycle 6.
